int_cal_pipe: RTL and testbench

INT_CAL_PIPE -- requirements
Module: int_cal_pipe

---
 rtl/int_cal_if.sv | 13 +
 rtl/int_cal_pipe.sv | 98 +++++++++
 tb/tb_int_cal_pipe.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/int_cal_if.sv
// int_cal_if: sample-in / corrected-count-out bundle for int_cal_pipe.
interface int_cal_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] int_in;
    logic             cal_en;
    logic [OUT_W-1:0] int_data;
    logic             int_valid;
    logic             int_err;
    modport master (output int_in, cal_en, input int_data, int_valid, int_err);
    modport slave  (input int_in, cal_en, output int_data, int_valid, int_err);
endinterface

// File: rtl/int_cal_pipe.sv
// int_cal_pipe: pipelined thermometer popcount minus OFFSET, saturating at 0 with underflow flag.
// INT_BUBBLE_FIX_EN adds a registered 3-bit majority bubble-removal pre-stage (one extra cycle).
module int_cal_pipe #(
    parameter int WIDTH  = 16,
    parameter int OFFSET = 1
) (
    input logic     clk,
    input logic     rst,
    int_cal_if.slave bus
);
    localparam int OUT_W = $clog2(WIDTH + 1);
    localparam int LVL   = $clog2(WIDTH);

    logic [WIDTH-1:0] w_bits;
    logic             w_vld;

`ifdef INT_BUBBLE_FIX_EN
    // Virtual neighbours: below bit 0 reads as 1, above the top bit reads as 0.
    logic [WIDTH+1:0] w_ext;
    logic [WIDTH-1:0] r_pre;
    logic             r_pre_vld;
    assign w_ext = {1'b0, bus.int_in, 1'b1};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre     <= '0;
            r_pre_vld <= 1'b0;
        end else begin
            r_pre_vld <= bus.cal_en;
            if (bus.cal_en)
                for (int i = 0; i < WIDTH; i++)
                    r_pre[i] <= (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) | (w_ext[i+1] & w_ext[i+2]);
        end
    end
    assign w_bits = r_pre;
    assign w_vld  = r_pre_vld;
`else
    assign w_bits = bus.int_in;
    assign w_vld  = bus.cal_en;
`endif

    for (genvar s = 1; s <= LVL; s++) begin : g_lvl
        localparam int N = WIDTH >> s;
        localparam int W = s + 1;
        logic [W-1:0] r_sum [N];
        logic [W-1:0] w_sum [N];
        logic         r_vld;
        logic         w_in_vld;
        if (s == 1) begin : g_first
            for (genvar j = 0; j < N; j++) begin : g_j
                assign w_sum[j] = W'(w_bits[2*j]) + W'(w_bits[2*j+1]);
            end
            assign w_in_vld = w_vld;
        end else begin : g_next
            for (genvar j = 0; j < N; j++) begin : g_j
                assign w_sum[j] = W'(g_lvl[s-1].r_sum[2*j]) + W'(g_lvl[s-1].r_sum[2*j+1]);
            end
            assign w_in_vld = g_lvl[s-1].r_vld;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_sum <= '{default: '0};
            end else begin
                r_vld <= w_in_vld;
                if (w_in_vld) r_sum <= w_sum;
            end
        end
    end

    // One extra bit on the difference gives a borrow that doubles as the underflow flag.
    logic [OUT_W-1:0] w_fin;
    logic [OUT_W:0]   w_diff;
    logic             w_fin_vld;
    logic [OUT_W-1:0] r_data;
    logic             r_valid;
    logic             r_err;
    assign w_fin     = g_lvl[LVL].r_sum[0];
    assign w_fin_vld = g_lvl[LVL].r_vld;
    assign w_diff    = {1'b0, w_fin} - (OUT_W + 1)'(OFFSET);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_fin_vld;
            if (w_fin_vld) begin
                r_data <= w_diff[OUT_W] ? '0 : w_diff[OUT_W-1:0];
                r_err  <= w_diff[OUT_W];
            end
        end
    end

    assign bus.int_data  = r_data;
    assign bus.int_valid = r_valid;
    assign bus.int_err   = r_err;
endmodule

// File: tb/tb_int_cal_pipe.sv
// tb_int_cal_pipe: scoreboard bench for int_cal_pipe (WIDTH=16/OFFSET=1 plus a WIDTH=32/OFFSET=0 instance).
module tb_int_cal_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int_cal_if #(.WIDTH(16)) bus ();
    int_cal_if #(.WIDTH(32)) bus32 ();

    int_cal_pipe #(.WIDTH(16), .OFFSET(1)) dut   (.clk(clk), .rst(rst), .bus(bus));
    int_cal_pipe #(.WIDTH(32), .OFFSET(0)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

`ifdef INT_BUBBLE_FIX_EN
    localparam int FIX = 1;
`else
    localparam int FIX = 0;
`endif
    localparam int L   = 5 + FIX;
    localparam int L32 = 6 + FIX;

    typedef struct {
        logic [4:0] d;
        logic       e;
        int         due;
    } exp_t;
    exp_t q[$];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.int_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: cycle %0d data=%0d err=%0d, required no valid", cyc, bus.int_data, bus.int_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.int_data !== e.d || bus.int_err !== e.e || cyc != e.due) begin
                    errors++;
                    $display("FAIL scoreboard: got data=%0d err=%0d cycle=%0d, required data=%0d err=%0d cycle=%0d",
                             bus.int_data, bus.int_err, cyc, e.d, e.e, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] v, input logic [4:0] d, input logic e);
        @(posedge clk);
        #1;
        bus.int_in = v;
        bus.cal_en = 1'b1;
        q.push_back('{d, e, cyc + L});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.cal_en = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_pending", q.size(), 0);
    endtask

    initial begin
        int k;
        bit seen;
        bus.int_in   = '0;
        bus.cal_en   = 1'b0;
        bus32.int_in = '0;
        bus32.cal_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", bus.int_valid, 0);
        check("reset_data", bus.int_data, 0);
        check("reset_err", bus.int_err, 0);

        // sample in flight gets flushed by a reset two cycles later
        @(posedge clk);
        #1;
        bus.int_in = 16'h00FF;
        bus.cal_en = 1'b1;
        @(posedge clk);
        #1 bus.cal_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("flush_outputs", {bus.int_valid, bus.int_data, bus.int_err}, 0);
        end

        send(16'h00FF, 5'd7, 1'b0);
        idle(1);
        drain();
        idle(3);
        @(negedge clk);
        check("hold_data", bus.int_data, 7);
        check("hold_err", bus.int_err, 0);
        check("hold_valid", bus.int_valid, 0);

        send(16'hFFFF, 5'd15, 1'b0);
        send(16'h0001, 5'd0, 1'b0);
        send(16'h0003, 5'd1, 1'b0);
        send(16'h0000, 5'd0, 1'b1);
        send(16'h00F7, FIX ? 5'd7 : 5'd6, 1'b0);
        send(16'h8000, 5'd0, FIX ? 1'b1 : 1'b0);
        send(16'h0F0F, 5'd7, 1'b0);
        send(16'h7FFF, 5'd14, 1'b0);
        idle(1);
        drain();

        // WIDTH=32 full-scale count must not overflow
        @(posedge clk);
        #1;
        bus32.int_in = '1;
        bus32.cal_en = 1'b1;
        k = cyc;
        @(posedge clk);
        #1 bus32.cal_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus32.int_valid) begin
                seen = 1'b1;
                check("w32_latency", cyc - k, L32);
                check("w32_data", bus32.int_data, 32);
                check("w32_err", bus32.int_err, 0);
            end
        end
        check("w32_seen", seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
